// File: rtl/cpu_io_pkg.sv
// Shared types and CPU-facing defaults for the output drain path.
package cpu_io_pkg;
   localparam int CPU_DATA_WIDTH  = 16;
   localparam int CPU_VECTOR_SIZE = 6;

   typedef enum logic {IDLE, SEND} drain_state_t;
endpackage

// File: rtl/vector_fifo.sv
// Synchronous FIFO with head read straight out of the storage array.
module vector_fifo #(
   parameter  int WIDTH = 96,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/vector_out_drain.sv
// Buffers CPU output vectors and streams them lane by lane to a slow sink.
module vector_out_drain
   import cpu_io_pkg::*;
#(
   parameter int DATA_WIDTH  = CPU_DATA_WIDTH,
   parameter int VECTOR_SIZE = CPU_VECTOR_SIZE,
   parameter int FIFO_DEPTH  = 4,
   parameter int IDX_WIDTH   = $clog2(VECTOR_SIZE)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorIn,
   input  logic                              vectorValid,
   output logic [DATA_WIDTH-1:0]             elementData,
   output logic [IDX_WIDTH-1:0]              elementIndex,
   output logic                              elementLast,
   output logic                              elementValid,
   input  logic                              elementReady,
   output logic [$clog2(FIFO_DEPTH):0]       fifoCount,
   output logic                              overflow
);
   localparam int VW = VECTOR_SIZE*DATA_WIDTH;
   localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(VECTOR_SIZE-1);

   drain_state_t  state;
   logic [VW-1:0] shreg, head;
   logic          full, empty, xfer, pop, push;

   assign xfer = elementValid && elementReady;
   // Refill on the last-lane transfer keeps back-to-back vectors bubble-free.
   assign pop  = !empty && ((state == IDLE) || (xfer && elementLast));
   assign push = vectorValid && (!full || pop);

   vector_fifo #(.WIDTH(VW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (vectorIn),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifoCount)
   );

   assign elementData = shreg[DATA_WIDTH-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         shreg        <= '0;
         elementIndex <= '0;
         elementLast  <= 1'b0;
         elementValid <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         if (vectorValid && !push) overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg        <= head;
                  elementIndex <= '0;
                  elementLast  <= (LAST == '0);
                  elementValid <= 1'b1;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (!elementLast) begin
                     shreg        <= shreg >> DATA_WIDTH;
                     elementIndex <= elementIndex + IDX_WIDTH'(1);
                     elementLast  <= (elementIndex + IDX_WIDTH'(1) == LAST);
                  end else if (pop) begin
                     shreg        <= head;
                     elementIndex <= '0;
                     elementLast  <= (LAST == '0);
                  end else begin
                     shreg        <= '0;
                     elementIndex <= '0;
                     elementLast  <= 1'b0;
                     elementValid <= 1'b0;
                     state        <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vector_out_drain.sv
// Directed bench for vector_out_drain with hand-derived expected streams.
module tb_vector_out_drain;
   logic        clock = 1'b0;
   logic        reset;
   logic [95:0] vectorIn;
   logic        vectorValid;
   logic [15:0] elementData;
   logic [2:0]  elementIndex;
   logic        elementLast;
   logic        elementValid;
   logic        elementReady;
   logic [2:0]  fifoCount;
   logic        overflow;

   int vectors     = 0;
   int miscompares = 0;
   int exp_idx;

   vector_out_drain dut (
      .clock        (clock),
      .reset        (reset),
      .vectorIn     (vectorIn),
      .vectorValid  (vectorValid),
      .elementData  (elementData),
      .elementIndex (elementIndex),
      .elementLast  (elementLast),
      .elementValid (elementValid),
      .elementReady (elementReady),
      .fifoCount    (fifoCount),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   function automatic logic [95:0] mkvec(input logic [15:0] base);
      logic [95:0] v;
      for (int i = 0; i < 6; i++) v[i*16 +: 16] = base + 16'(i);
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, 32'(elementValid), 32'd0);
      chk({tag, "_data"},  32'(elementData),  32'd0);
      chk({tag, "_idx"},   32'(elementIndex), 32'd0);
      chk({tag, "_last"},  32'(elementLast),  32'd0);
      chk({tag, "_count"}, 32'(fifoCount),    32'd0);
      chk({tag, "_ovf"},   32'(overflow),     32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      vectorIn     = '0;
      vectorValid  = 1'b0;
      elementReady = 1'b0;
      #2;
      chk_idle_outputs("reset");
      step();
      reset = 1'b0;

      // Single vector, 2-cycle latency, lanes 1..6.
      vectorIn = mkvec(16'h0001); vectorValid = 1'b1; elementReady = 1'b1;
      step();
      vectorValid = 1'b0;
      chk("single_cnt1",   32'(fifoCount),    32'd1);
      chk("single_nvalid", 32'(elementValid), 32'd0);
      step();
      chk("single_cnt0", 32'(fifoCount), 32'd0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         chk("single_valid", 32'(elementValid), 32'd1);
         chk("single_data",  32'(elementData),  32'(i + 1));
         chk("single_idx",   32'(elementIndex), 32'(i));
         chk("single_last",  32'(elementLast),  32'(i == 5));
      end
      step();
      chk("single_idle", 32'(elementValid), 32'd0);

      // Backpressure: ready pattern 1,0,0 repeating.
      elementReady = 1'b0;
      vectorIn = mkvec(16'h0010); vectorValid = 1'b1;
      step();
      vectorValid = 1'b0;
      step();
      exp_idx = 0;
      for (int c = 0; c < 30 && exp_idx < 6; c++) begin
         elementReady = (c % 3 == 0);
         step();
         if (elementReady) exp_idx++;
         if (exp_idx < 6) begin
            chk("bp_idx",  32'(elementIndex), 32'(exp_idx));
            chk("bp_data", 32'(elementData),  32'(16'h0010 + 16'(exp_idx)));
         end
      end
      chk("bp_done", 32'(exp_idx), 32'd6);
      chk("bp_idle", 32'(elementValid), 32'd0);

      // Burst of 5, ready=1: 30 contiguous elements starting after edge 2.
      elementReady = 1'b1;
      for (int c = 1; c <= 31; c++) begin
         vectorValid = (c <= 5);
         vectorIn    = mkvec(16'((c) << 8));
         step();
         if (c >= 2) begin
            chk("burst_valid", 32'(elementValid), 32'd1);
            chk("burst_data",  32'(elementData),
                32'(16'(((c - 2) / 6 + 1) << 8) + 16'((c - 2) % 6)));
         end
      end
      vectorValid = 1'b0;
      step();
      chk("burst_idle", 32'(elementValid), 32'd0);
      chk("burst_ovf",  32'(overflow),     32'd0);

      // Full FIFO with a capture on the same edge as the last-lane transfer.
      elementReady = 1'b0;
      for (int v = 0; v < 5; v++) begin
         vectorIn = mkvec(16'h3000 + 16'(v << 8)); vectorValid = 1'b1;
         step();
      end
      vectorValid = 1'b0;
      chk("full_cnt4", 32'(fifoCount), 32'd4);
      elementReady = 1'b1;
      repeat (5) step();
      chk("full_last", 32'(elementLast), 32'd1);
      vectorIn = mkvec(16'h3500); vectorValid = 1'b1;
      step();
      vectorValid = 1'b0;
      chk("full_cnt_hold", 32'(fifoCount),   32'd4);
      chk("full_ovf",      32'(overflow),    32'd0);
      chk("full_data",     32'(elementData), 32'h3100);
      for (int n = 7; n < 36; n++) begin
         step();
         chk("full_drain", 32'(elementData), 32'(16'h3000 + 16'((n / 6) << 8) + 16'(n % 6)));
      end
      step();
      chk("full_idle", 32'(elementValid), 32'd0);

      // Overflow: 6 captures with the sink stalled, sixth is dropped.
      elementReady = 1'b0;
      for (int v = 0; v < 6; v++) begin
         vectorIn = mkvec(16'h2000 + 16'(v << 8)); vectorValid = 1'b1;
         step();
      end
      vectorValid = 1'b0;
      chk("ovf_flag",  32'(overflow),    32'd1);
      chk("ovf_cnt",   32'(fifoCount),   32'd4);
      chk("ovf_head",  32'(elementData), 32'h2000);
      elementReady = 1'b1;
      for (int n = 0; n < 30; n++) begin
         chk("ovf_drain", 32'(elementData), 32'(16'h2000 + 16'((n / 6) << 8) + 16'(n % 6)));
         step();
      end
      chk("ovf_idle",   32'(elementValid), 32'd0);
      chk("ovf_sticky", 32'(overflow),     32'd1);

      // Reset mid-vector at lane 3 with two vectors queued.
      elementReady = 1'b0;
      for (int v = 0; v < 3; v++) begin
         vectorIn = mkvec(16'h4000 + 16'(v << 8)); vectorValid = 1'b1;
         step();
      end
      vectorValid = 1'b0;
      elementReady = 1'b1;
      repeat (3) step();
      elementReady = 1'b0;
      chk("rst_pre_idx", 32'(elementIndex), 32'd3);
      chk("rst_pre_cnt", 32'(fifoCount),    32'd2);
      #2 reset = 1'b1;
      #1;
      chk_idle_outputs("rst_async");
      #2 reset = 1'b0;
      elementReady = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("rst_after_valid", 32'(elementValid), 32'd0);
      end
      chk("rst_after_cnt", 32'(fifoCount), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
